// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the I-cache fetch stage and decode.
//
// Accepts up to two 32-bit instruction words per cycle from fetch, compacted in
// program order, and presents one instruction plus its PC per cycle to decode
// (first-word-fall-through from registered storage). A flush empties the queue
// in one cycle.
//
// Optional feature: define FETCHQ_BYPASS_EN to let a push into an empty queue
// appear on dec_* in the same cycle. If decode also accepts that word in the
// same cycle, the word is not enqueued.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous, active-high reset
//   flush_i            redirect/mispredict flush; wins over push and pop
//   fetch_valid_i      per-slot valid (bit0 = slot0, bit1 = slot1)
//   fetch_inst0_i      slot0 instruction word
//   fetch_inst1_i      slot1 instruction word
//   fetch_pc_i         PC of slot0; slot1 PC is fetch_pc_i + 4
//   fetch_ready_o      queue can take two words this cycle
//   dec_valid_o        head entry valid toward decode
//   dec_inst_o         head instruction word (0 when not valid)
//   dec_pc_o           head PC (0 when not valid)
//   pipe_load_decode_i decode accepts the head entry
//   count_o            current occupancy
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic [1:0]                 fetch_valid_i,
  input  logic [31:0]                fetch_inst0_i,
  input  logic [31:0]                fetch_inst1_i,
  input  logic [PC_W-1:0]            fetch_pc_i,
  output logic                       fetch_ready_o,
  output logic                       dec_valid_o,
  output logic [31:0]                dec_inst_o,
  output logic [PC_W-1:0]            dec_pc_o,
  input  logic                       pipe_load_decode_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [31:0]     mem_inst [DEPTH];
  logic [PC_W-1:0] mem_pc   [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [PC_W-1:0]  pc_slot1;
  logic             push_ok;
  logic             pop_q;
  logic             byp;
  logic             byp_take;
  logic [1:0]       n_push;
  logic [1:0]       n_write;
  logic [31:0]      first_inst;
  logic [PC_W-1:0]  first_pc;
  logic             has_second;
  logic [31:0]      w0_inst;
  logic [PC_W-1:0]  w0_pc;
  logic [PTR_W-1:0] wr_ptr_p1;

  assign fetch_ready_o = (count <= READY_MAX);
  assign count_o       = count;
  assign pc_slot1      = fetch_pc_i + PC_W'(4);
  assign wr_ptr_p1     = wr_ptr + PTR_W'(1);

  always_comb begin
    push_ok    = (|fetch_valid_i) && fetch_ready_o && !flush_i && !reset;
    pop_q      = (count != '0) && pipe_load_decode_i && !flush_i;
    n_push     = push_ok ? ({1'b0, fetch_valid_i[0]} + {1'b0, fetch_valid_i[1]}) : 2'd0;
    first_inst = fetch_valid_i[0] ? fetch_inst0_i : fetch_inst1_i;
    first_pc   = fetch_valid_i[0] ? fetch_pc_i    : pc_slot1;
    has_second = (fetch_valid_i == 2'b11);

`ifdef FETCHQ_BYPASS_EN
    byp      = push_ok && (count == '0);
    byp_take = byp && pipe_load_decode_i;
`else
    byp      = 1'b0;
    byp_take = 1'b0;
`endif

    // A word consumed straight off the bypass is dropped; the remaining slot
    // (if any) moves down into the first write position.
    if (byp_take) begin
      w0_inst = fetch_inst1_i;
      w0_pc   = pc_slot1;
      n_write = n_push - 2'd1;
    end else begin
      w0_inst = first_inst;
      w0_pc   = first_pc;
      n_write = n_push;
    end

    dec_valid_o = 1'b0;
    dec_inst_o  = '0;
    dec_pc_o    = '0;
    if (byp) begin
      dec_valid_o = 1'b1;
      dec_inst_o  = first_inst;
      dec_pc_o    = first_pc;
    end else if (count != '0) begin
      dec_valid_o = 1'b1;
      dec_inst_o  = mem_inst[rd_ptr];
      dec_pc_o    = mem_pc[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_q);
      wr_ptr <= wr_ptr + PTR_W'(n_write);
      count  <= count + CNT_W'(n_write) - CNT_W'(pop_q);
    end
  end

  // Storage is not reset; writes are already gated by push_ok.
  always_ff @(posedge clock) begin
    if (n_write != 2'd0) begin
      mem_inst[wr_ptr] <= w0_inst;
      mem_pc[wr_ptr]   <= w0_pc;
    end
    if (n_write == 2'd2 && has_second) begin
      mem_inst[wr_ptr_p1] <= fetch_inst1_i;
      mem_pc[wr_ptr_p1]   <= pc_slot1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=8, PC_W=64).
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic        flush_i;
  logic [1:0]  fetch_valid_i;
  logic [31:0] fetch_inst0_i;
  logic [31:0] fetch_inst1_i;
  logic [63:0] fetch_pc_i;
  logic        fetch_ready_o;
  logic        dec_valid_o;
  logic [31:0] dec_inst_o;
  logic [63:0] dec_pc_o;
  logic        pipe_load_decode_i;
  logic [3:0]  count_o;

  int unsigned tests;
  int unsigned fails;

  fetch_queue #(.DEPTH(8), .PC_W(64)) dut (
    .clock              (clock),
    .reset              (reset),
    .flush_i            (flush_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_inst0_i      (fetch_inst0_i),
    .fetch_inst1_i      (fetch_inst1_i),
    .fetch_pc_i         (fetch_pc_i),
    .fetch_ready_o      (fetch_ready_o),
    .dec_valid_o        (dec_valid_o),
    .dec_inst_o         (dec_inst_o),
    .dec_pc_o           (dec_pc_o),
    .pipe_load_decode_i (pipe_load_decode_i),
    .count_o            (count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [1:0]  v;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [63:0] pc;
    logic        pop;
    logic [3:0]  cnt;
    logic        dv;
    logic [31:0] di;
    logic [63:0] dp;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic fl, input logic [1:0] v,
                     input logic [31:0] i0, input logic [31:0] i1,
                     input logic [63:0] pc, input logic pop,
                     input logic [3:0] cnt, input logic dv,
                     input logic [31:0] di, input logic [63:0] dp,
                     input logic rdy);
    vec_t e;
    e.rst = rst; e.fl = fl; e.v = v; e.i0 = i0; e.i1 = i1; e.pc = pc;
    e.pop = pop; e.cnt = cnt; e.dv = dv; e.di = di; e.dp = dp; e.rdy = rdy;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; flush_i = 1'b0; fetch_valid_i = 2'b00;
    fetch_inst0_i = '0; fetch_inst1_i = '0; fetch_pc_i = '0;
    pipe_load_decode_i = 1'b0;
  endtask

  task automatic drive(input logic rst, input logic fl, input logic [1:0] v,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [63:0] pc, input logic pop);
    reset = rst; flush_i = fl; fetch_valid_i = v;
    fetch_inst0_i = i0; fetch_inst1_i = i1; fetch_pc_i = pc;
    pipe_load_decode_i = pop;
    #1;
    if (v != 2'b00 && !fetch_ready_o && !rst && !fl)
      $display("NOTE: producer pushes while fetch_ready_o=0 (word(s) dropped)");
  endtask

  // Apply inputs for one rising edge, then return inputs to idle and settle.
  task automatic step(input logic rst, input logic fl, input logic [1:0] v,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [63:0] pc, input logic pop);
    drive(rst, fl, v, i0, i1, pc, pop);
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  task automatic check_head(input string tag, input logic [3:0] cnt, input logic dv,
                            input logic [31:0] di, input logic [63:0] dp, input logic rdy);
    check({tag, ".count"}, 64'(count_o), 64'(cnt));
    check({tag, ".valid"}, 64'(dec_valid_o), 64'(dv));
    check({tag, ".inst"},  64'(dec_inst_o), 64'(di));
    check({tag, ".pc"},    dec_pc_o, dp);
    check({tag, ".ready"}, 64'(fetch_ready_o), 64'(rdy));
  endtask

  localparam logic [31:0] A = 32'h00500093;
  localparam logic [31:0] B = 32'h00108113;

  initial begin
    tests = 0;
    fails = 0;
    idle();
    reset = 1'b1;

    // rst fl  v      i0            i1            pc                       pop  cnt dv di            dp                       rdy
    add(1, 0, 2'b00, '0, '0, '0, 0,                                          0, 0, '0, '0, 1);
    add(1, 0, 2'b00, '0, '0, '0, 0,                                          0, 0, '0, '0, 1);
    add(0, 0, 2'b11, A, B, 64'h1000, 0,                                      2, 1, A, 64'h1000, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          1, 1, B, 64'h1004, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          0, 0, '0, '0, 1);
    // fill to DEPTH, pointer wraps past the end of storage
    add(0, 0, 2'b11, 32'hC0, 32'hC1, 64'h3000, 0,                            2, 1, 32'hC0, 64'h3000, 1);
    add(0, 0, 2'b11, 32'hC2, 32'hC3, 64'h3008, 0,                            4, 1, 32'hC0, 64'h3000, 1);
    add(0, 0, 2'b11, 32'hC4, 32'hC5, 64'h3010, 0,                            6, 1, 32'hC0, 64'h3000, 1);
    add(0, 0, 2'b11, 32'hC6, 32'hC7, 64'h3018, 0,                            8, 1, 32'hC0, 64'h3000, 0);
    add(0, 0, 2'b11, 32'hD0, 32'hD1, 64'h4000, 0,                            8, 1, 32'hC0, 64'h3000, 0);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          7, 1, 32'hC1, 64'h3004, 0);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          6, 1, 32'hC2, 64'h3008, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          5, 1, 32'hC3, 64'h300C, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          4, 1, 32'hC4, 64'h3010, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          3, 1, 32'hC5, 64'h3014, 1);
    // simultaneous push 2'b01 and pop at count 3
    add(0, 0, 2'b01, 32'hE0, 32'hEE, 64'h5000, 1,                            3, 1, 32'hC6, 64'h3018, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          2, 1, 32'hC7, 64'h301C, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          1, 1, 32'hE0, 64'h5000, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          0, 0, '0, '0, 1);
    // PC wrap on slot1
    add(0, 0, 2'b11, 32'hF0, 32'hF1, 64'hFFFF_FFFF_FFFF_FFFC, 0,             2, 1, 32'hF0, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          1, 1, 32'hF1, 64'h0, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          0, 0, '0, '0, 1);
    // slot1 only
    add(0, 0, 2'b10, 32'h60, 32'h61, 64'h2000, 0,                            1, 1, 32'h61, 64'h2004, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          0, 0, '0, '0, 1);
    // build count 5 then flush with push and pop
    add(0, 0, 2'b11, 32'h70, 32'h71, 64'h6000, 0,                            2, 1, 32'h70, 64'h6000, 1);
    add(0, 0, 2'b11, 32'h72, 32'h73, 64'h6008, 0,                            4, 1, 32'h70, 64'h6000, 1);
    add(0, 0, 2'b01, 32'h74, 32'h7F, 64'h6010, 0,                            5, 1, 32'h70, 64'h6000, 1);
    add(0, 1, 2'b11, 32'h80, 32'h81, 64'h7000, 1,                            0, 0, '0, '0, 1);
    add(0, 0, 2'b01, 32'h90, 32'h9F, 64'h8000, 0,                            1, 1, 32'h90, 64'h8000, 1);
    // reset mid-operation with a push
    add(1, 0, 2'b11, 32'hA0, 32'hA1, 64'h8100, 0,                            0, 0, '0, '0, 1);
    // pop on empty queue is ignored
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          0, 0, '0, '0, 1);
    add(0, 0, 2'b01, 32'hB0, 32'hBF, 64'h9000, 0,                            1, 1, 32'hB0, 64'h9000, 1);
    add(0, 0, 2'b00, '0, '0, '0, 1,                                          0, 0, '0, '0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].fl, vecs[i].v, vecs[i].i0, vecs[i].i1, vecs[i].pc, vecs[i].pop);
      check_head($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dv, vecs[i].di, vecs[i].dp, vecs[i].rdy);
    end

    // Count DEPTH-1: a single-slot push is stalled too, then drain in order.
    step(0, 0, 2'b11, 32'hA000_0000, 32'hA000_0001, 64'hB000, 0);
    step(0, 0, 2'b11, 32'hA000_0002, 32'hA000_0003, 64'hB008, 0);
    step(0, 0, 2'b11, 32'hA000_0004, 32'hA000_0005, 64'hB010, 0);
    step(0, 0, 2'b01, 32'hA000_0006, 32'h0, 64'hB018, 0);
    check("full7.count", 64'(count_o), 64'd7);
    check("full7.ready", 64'(fetch_ready_o), 64'd0);
    step(0, 0, 2'b01, 32'hDEAD_BEEF, 32'h0, 64'hC000, 0);
    check("full7.drop", 64'(count_o), 64'd7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("drain%0d.inst", i), 64'(dec_inst_o), 64'(32'hA000_0000 + i));
      check($sformatf("drain%0d.pc", i), dec_pc_o, 64'hB000 + 64'(4 * i));
      step(0, 0, 2'b00, '0, '0, '0, 1);
    end
    check("drain.empty", 64'(dec_valid_o), 64'd0);

`ifdef FETCHQ_BYPASS_EN
    // Bypass with same-cycle pop: slot0 consumed, slot1 enqueued.
    drive(0, 0, 2'b11, 32'hE000_0000, 32'hE000_0001, 64'hD000, 1);
    check("byp.valid", 64'(dec_valid_o), 64'd1);
    check("byp.inst", 64'(dec_inst_o), 64'hE000_0000);
    check("byp.pc", dec_pc_o, 64'hD000);
    @(posedge clock); #1; idle(); #1;
    check_head("byp.after", 4'd1, 1'b1, 32'hE000_0001, 64'hD004, 1'b1);
    step(0, 0, 2'b00, '0, '0, '0, 1);
    // Bypass without pop: both words enqueued.
    drive(0, 0, 2'b11, 32'hE000_0002, 32'hE000_0003, 64'hD100, 0);
    check("byp2.inst", 64'(dec_inst_o), 64'hE000_0002);
    @(posedge clock); #1; idle(); #1;
    check_head("byp2.after", 4'd2, 1'b1, 32'hE000_0002, 64'hD100, 1'b1);
    step(0, 0, 2'b00, '0, '0, '0, 1);
    step(0, 0, 2'b00, '0, '0, '0, 1);
    check("byp2.empty", 64'(count_o), 64'd0);
`else
    // No combinational path: a push into an empty queue is not visible yet.
    drive(0, 0, 2'b11, 32'hE000_0000, 32'hE000_0001, 64'hD000, 1);
    check("nobyp.valid", 64'(dec_valid_o), 64'd0);
    check("nobyp.inst", 64'(dec_inst_o), 64'd0);
    @(posedge clock); #1; idle(); #1;
    check_head("nobyp.after", 4'd2, 1'b1, 32'hE000_0000, 64'hD000, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
